// File: rtl/led_ring_pkg.sv
// Shared types and helpers for the LED-ring controller: display modes,
// brightness lookup and ring mask generation.
package led_ring_pkg;

  typedef enum logic [1:0] {
    MODE_DOT  = 2'd0,
    MODE_BAR  = 2'd1,
    MODE_IDOT = 2'd2,
    MODE_IBAR = 2'd3
  } mode_e;

  localparam int MAX_LEDS = 64;

  // Level 0 is the dimmest non-off value; level k doubles the exponent step.
  function automatic logic [7:0] intensity_lut(input logic [2:0] sel);
    int sh;
    if (sel == 3'd0) return 8'h01;
    sh = 2 * int'(sel) - 1;
    if (sh >= 8) return 8'hFF;
    return 8'(1 << sh);
  endfunction

  // Bits at or above n are always cleared so inverted modes stay inside the ring.
  function automatic logic [MAX_LEDS-1:0] ring_mask(input logic [5:0] pos,
                                                    input mode_e mode,
                                                    input int n);
    logic [MAX_LEDS-1:0] m;
    logic on;
    int p;
    p = int'(pos);
    m = '0;
    for (int i = 0; i < MAX_LEDS; i++) begin
      on = (mode == MODE_DOT || mode == MODE_IDOT) ? (i == p) : (i <= p);
      if (mode == MODE_IDOT || mode == MODE_IBAR) on = !on;
      m[i] = on && (i < n);
    end
    return m;
  endfunction

endpackage

// File: rtl/led_ring_frame_reg.sv
// Frame output stage: holds a presented frame stable until accepted and
// remembers (via dirty) that newer working state still has to be sent.
module led_ring_frame_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              upd_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q, valid_d;
  logic              dirty_q, dirty_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              load;

  // An update arriving on a load edge keeps dirty set, so it is sent next frame.
  always_comb begin
    load    = (!valid_q || ready_i) && dirty_q;
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
    dirty_d = upd_i || (dirty_q && !load);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      dirty_q <= 1'b1;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/led_ring_ctrl.sv
// Rotary/LED-ring controller: tracks encoder position and display mode,
// maps the brightness selector, and hands frames to the WS2812B serialiser.
module led_ring_ctrl
  import led_ring_pkg::*;
#(
  parameter int NUM_LEDS = 12,
  parameter int WRAP     = 1,
  parameter int SEL_W    = 2,
  parameter int POS_W    = $clog2(NUM_LEDS)
) (
  input  logic                 clk,
  input  logic                 res,
  input  logic                 rot_up,
  input  logic                 rot_dn,
  input  logic                 push,
  input  logic [SEL_W-1:0]     intensity_in,
  input  logic                 frame_ready,
  output logic                 frame_valid,
  output logic [NUM_LEDS-1:0]  led_mask,
  output logic [7:0]           intensity_out,
  output logic [2+POS_W-1:0]   state_out
);

  localparam int          FW   = NUM_LEDS + 8 + 2 + POS_W;
  localparam logic [POS_W-1:0] LAST = POS_W'(NUM_LEDS - 1);

  logic [POS_W-1:0] pos_q, pos_d;
  mode_e            mode_q, mode_d;
  logic [SEL_W-1:0] sel_q;
  logic             upd;
  logic [NUM_LEDS-1:0] mask_w;
  logic [FW-1:0]    frame_w, frame_o;

  // Opposing pulses cancel; a saturated step leaves pos_d == pos_q.
  always_comb begin
    pos_d  = pos_q;
    mode_d = mode_q;
    if (rot_up && !rot_dn) begin
      if (pos_q == LAST) pos_d = (WRAP != 0) ? '0 : pos_q;
      else               pos_d = pos_q + POS_W'(1);
    end else if (rot_dn && !rot_up) begin
      if (pos_q == '0) pos_d = (WRAP != 0) ? LAST : pos_q;
      else             pos_d = pos_q - POS_W'(1);
    end
    if (push) mode_d = mode_e'(mode_q + 2'd1);
    upd = (pos_d != pos_q) || push || (intensity_in != sel_q);
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      pos_q  <= '0;
      mode_q <= MODE_DOT;
      sel_q  <= '0;
    end else begin
      pos_q  <= pos_d;
      mode_q <= mode_d;
      sel_q  <= intensity_in;
    end
  end

  assign mask_w  = NUM_LEDS'(ring_mask(6'(pos_q), mode_q, NUM_LEDS));
  assign frame_w = {mode_q, pos_q, intensity_lut(3'(sel_q)), mask_w};

  led_ring_frame_reg #(.DATA_W(FW)) u_frame (
    .clk     (clk),
    .rst     (res),
    .upd_i   (upd),
    .data_i  (frame_w),
    .ready_i (frame_ready),
    .valid_o (frame_valid),
    .data_o  (frame_o)
  );

  assign state_out     = frame_o[FW-1 -: 2+POS_W];
  assign intensity_out = frame_o[NUM_LEDS +: 8];
  assign led_mask      = frame_o[NUM_LEDS-1:0];

endmodule

// File: tb/tb_led_ring_ctrl.sv
// Directed bench for led_ring_ctrl: a wrapping 2-bit-selector instance (a_*)
// and a saturating 3-bit-selector instance (b_*) sharing clock and reset.
module tb_led_ring_ctrl;

  logic clk = 1'b0;
  logic res = 1'b0;
  always #5 clk = ~clk;

  logic        a_up = 0, a_dn = 0, a_push = 0, a_rdy = 1;
  logic [1:0]  a_sel = 0;
  logic        a_fv;
  logic [11:0] a_mask;
  logic [7:0]  a_int;
  logic [5:0]  a_st;

  logic        b_up = 0, b_dn = 0, b_push = 0, b_rdy = 1;
  logic [2:0]  b_sel = 0;
  logic        b_fv;
  logic [11:0] b_mask;
  logic [7:0]  b_int;
  logic [5:0]  b_st;

  int checks = 0;
  int failures = 0;

  led_ring_ctrl #(.NUM_LEDS(12), .WRAP(1), .SEL_W(2)) dut_a (
    .clk(clk), .res(res), .rot_up(a_up), .rot_dn(a_dn), .push(a_push),
    .intensity_in(a_sel), .frame_ready(a_rdy), .frame_valid(a_fv),
    .led_mask(a_mask), .intensity_out(a_int), .state_out(a_st)
  );

  led_ring_ctrl #(.NUM_LEDS(12), .WRAP(0), .SEL_W(3)) dut_b (
    .clk(clk), .res(res), .rot_up(b_up), .rot_dn(b_dn), .push(b_push),
    .intensity_in(b_sel), .frame_ready(b_rdy), .frame_valid(b_fv),
    .led_mask(b_mask), .intensity_out(b_int), .state_out(b_st)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One-cycle pulse; afterwards the resulting frame (if any) is visible.
  task automatic pa(input logic u, input logic d, input logic p);
    a_up = u; a_dn = d; a_push = p;
    step();
    a_up = 0; a_dn = 0; a_push = 0;
    step();
  endtask

  task automatic pb(input logic u, input logic d);
    b_up = u; b_dn = d;
    step();
    b_up = 0; b_dn = 0;
    step();
  endtask

  logic [7:0] lut_exp [4];

  initial begin
    lut_exp[0] = 8'h02; lut_exp[1] = 8'h08; lut_exp[2] = 8'h20; lut_exp[3] = 8'h01;

    #3 res = 1;
    #1;
    chk("rst_fv", a_fv, 0);
    chk("rst_mask", a_mask, 0);
    chk("rst_int", a_int, 0);
    chk("rst_st", a_st, 0);
    step();
    chk("rst_hold_fv", a_fv, 0);
    res = 0;
    step();
    chk("first_fv", a_fv, 1);
    chk("first_mask", a_mask, 12'h001);
    chk("first_int", a_int, 8'h01);
    chk("first_st", a_st, 0);
    step();
    chk("first_drop", a_fv, 0);

    // wrap at both ends
    pa(0, 1, 0);
    chk("wrapdn_mask", a_mask, 12'h800);
    chk("wrapdn_st", a_st, 6'd11);
    pa(1, 0, 0);
    chk("wrapup_mask", a_mask, 12'h001);
    chk("wrapup_st", a_st, 0);
    pa(0, 1, 0);
    chk("wrapdn2_mask", a_mask, 12'h800);

    // modes at pos 3
    for (int i = 0; i < 4; i++) pa(1, 0, 0);
    chk("pos3_mask", a_mask, 12'h008);
    pa(0, 0, 1);
    chk("bar_mask", a_mask, 12'h00F);
    chk("bar_st", a_st, 6'h13);
    pa(0, 0, 1);
    chk("idot_mask", a_mask, 12'hFF7);
    pa(0, 0, 1);
    chk("ibar_mask", a_mask, 12'hFF0);
    chk("ibar_st", a_st, 6'h33);
    pa(0, 0, 1);
    chk("dot_mask", a_mask, 12'h008);
    chk("dot_st", a_st, 6'h03);

    // back-pressure: intermediate positions dropped
    for (int i = 0; i < 3; i++) pa(0, 1, 0);
    chk("pos0_mask", a_mask, 12'h001);
    a_rdy = 0;
    for (int i = 0; i < 3; i++) begin
      pa(1, 0, 0);
      chk("frozen_mask", a_mask, 12'h001);
      chk("frozen_fv", a_fv, 1);
    end
    a_rdy = 1;
    step();
    chk("unfrz_mask", a_mask, 12'h008);
    chk("unfrz_fv", a_fv, 1);
    step();
    chk("unfrz_drop", a_fv, 0);

    // intensity sweep: frame two edges after the selector changes
    for (int k = 0; k < 4; k++) begin
      a_sel = 2'((k + 1) % 4);
      step();
      chk("sel_lat_fv", a_fv, 0);
      step();
      chk("sel_fv", a_fv, 1);
      chk("sel_int", a_int, lut_exp[k]);
    end

    // opposing pulses cancel
    pa(1, 1, 0);
    chk("cancel_fv", a_fv, 0);
    chk("cancel_st", a_st, 6'h03);

    // rotation on the handshake edge
    a_rdy = 0;
    pa(1, 0, 0);
    chk("hs_pre_mask", a_mask, 12'h010);
    chk("hs_pre_fv", a_fv, 1);
    a_rdy = 1; a_up = 1;
    step();
    a_up = 0;
    chk("hs_drop", a_fv, 0);
    step();
    chk("hs_next_fv", a_fv, 1);
    chk("hs_next_mask", a_mask, 12'h020);
    chk("hs_next_st", a_st, 6'h05);

    // reset while a frame is presented
    pa(1, 0, 0);
    chk("pre_rst_fv", a_fv, 1);
    chk("pre_rst_mask", a_mask, 12'h040);
    res = 1;
    #1;
    chk("midrst_fv", a_fv, 0);
    chk("midrst_mask", a_mask, 0);
    chk("midrst_int", a_int, 0);
    chk("midrst_st", a_st, 0);
    step();
    res = 0;
    step();
    chk("rerel_mask", a_mask, 12'h001);
    chk("rerel_fv", a_fv, 1);
    chk("b_first_mask", b_mask, 12'h001);
    step();

    // saturating instance
    pb(0, 1);
    chk("b_sat0_fv", b_fv, 0);
    chk("b_sat0_mask", b_mask, 12'h001);
    for (int i = 0; i < 11; i++) pb(1, 0);
    chk("b_top_mask", b_mask, 12'h800);
    chk("b_top_st", b_st, 6'd11);
    pb(1, 0);
    chk("b_sat_fv", b_fv, 0);
    chk("b_sat_mask", b_mask, 12'h800);
    b_sel = 3'd4;
    step();
    step();
    chk("b_sel4", b_int, 8'h80);
    b_sel = 3'd5;
    step();
    step();
    chk("b_sel5", b_int, 8'hFF);
    chk("b_sel5_fv", b_fv, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/led_ring_ctrl.md
Name: led_ring_ctrl

Overview:
- Parametrised next-generation rotary/LED-ring controller.
- Tracks encoder position over NUM_LEDS positions and cycles four display modes on push (dot, bar, inverted dot, inverted bar).
- Maps a selector to a WS2812B brightness byte.
- Hands complete frames (mask + intensity) to the WS2812B serialiser through a valid/ready handshake. Outputs are held stable until the serialiser accepts them.

Parameters:
- NUM_LEDS, 12: ring size, 2..64.
- WRAP, 1: 1 = position wraps at both ends; 0 = saturates at 0 and NUM_LEDS-1.
- SEL_W, 2: width of intensity selector, 1..3.
- POS_W, $clog2(NUM_LEDS): position counter width (derived; do not override).

Ports:
- clk, input, 1: system clock (40 MHz).
- res, input, 1: asynchronous active-high reset.
- rot_up, input, 1: one-cycle step-up pulse from the encoder decoder.
- rot_dn, input, 1: one-cycle step-down pulse.
- push, input, 1: one-cycle debounced button pulse.
- intensity_in, input, SEL_W: brightness selector.
- frame_ready, input, 1: serialiser accepts a frame.
- frame_valid, output, 1: a frame is presented.
- led_mask, output, NUM_LEDS: frame LED on-mask; bit i = LED i.
- intensity_out, output, 8: frame brightness byte.
- state_out, output, 2+POS_W: {mode, pos} of the presented frame, for the debug/7-seg path.

Behaviour:
- Reset (async assert, sync release) values:
  - pos=0, mode=DOT(0), dirty=1, frame_valid=0.
  - led_mask=0, intensity_out=0, state_out=0.
  - First frame (mask=1, DOT) is presented 1 cycle after reset release.
- Position, updated on the clk edge sampling the pulse:
  - rot_up only: pos+1. At NUM_LEDS-1 → 0 if WRAP, else hold.
  - rot_dn only: pos-1. At 0 → NUM_LEDS-1 if WRAP, else hold.
  - rot_up && rot_dn together: no change, dirty not set.
  - A saturated (held) step does not set dirty.
- Mode: push advances DOT(0) → BAR(1) → IDOT(2) → IBAR(3) → DOT.
  - Push in the same cycle as a rotation pulse: both applied.
- Working mask, combinational from pos/mode:
  - DOT: only bit pos set.
  - BAR: bits 0..pos set.
  - IDOT/IBAR: bitwise complement of DOT/BAR over NUM_LEDS bits.
- Intensity:
  - intensity_in is registered once (sel_q).
  - Level 0 → 8'h01. Level k>0 → 1<<(2k-1). Any shift ≥8 saturates to 8'hFF.
  - Default table is therefore 01, 02, 08, 20 (hex).
  - A sel_q change sets dirty.
- dirty is set on any accepted pos change, mode change or sel_q change.
- Output stage (stream semantics), evaluated each edge:
  - If (!frame_valid || frame_ready) && dirty: load led_mask / intensity_out / state_out from working state, frame_valid=1, dirty=0.
  - Else if frame_valid && frame_ready: frame_valid=0.
  - While frame_valid && !frame_ready: outputs frozen. Further events only update working state and set dirty, so the latest state is sent next. Intermediate states may be dropped; this is intended.
  - An event in the same cycle as a handshake is captured by dirty and sent in the following frame. It is never lost.
- Latency:
  - Rotation/push pulse at edge N updates working state.
  - Frame carrying it is valid after edge N+1 (output stage free).
  - Intensity change adds 1 cycle for the input register.
- Reset mid-frame: frame_valid drops immediately. Serialiser must abort the frame on res.

Decomposition:
- Package led_ring_pkg holds:
  - mode enum (MODE_DOT, MODE_BAR, MODE_IDOT, MODE_IBAR, 2 bits);
  - function intensity_lut(sel) → 8-bit;
  - function ring_mask(pos, mode, n).
- One natural sub-module: led_ring_frame_reg. It holds the output stage (dirty flag, valid/ready, frozen output registers) and is reusable by other frame producers.
- Position/mode/intensity logic lives in the top.

Test Plan:
- Reset release, frame_ready=1 → one-cycle valid frame: mask 12'h001, intensity_out 8'h01, state_out 0. frame_valid then 0.
- WRAP=1, pos=11, rot_up → mask 12'h001, pos 0. Then rot_dn → mask 12'h800. With WRAP=0, repeat at pos=11: no new frame, mask stays 12'h800.
- Push ×1 with pos=3 → BAR mask 12'h00F. Push ×2 more → IBAR mask 12'hFF0. Push again → DOT mask 12'h008.
- frame_ready=0, issue 3 rot_up from pos 0 → mask stays 12'h001 frozen. On frame_ready=1: next frame mask 12'h008; intermediate masks never presented.
- intensity_in sweep 0..3 → intensity_out 01, 02, 08, 20, each 2 cycles after the change. SEL_W=3, sel 5 → 8'hFF.
- Simultaneous rot_up+rot_dn → no frame. rot_up coinciding with a handshake → the new position appears in the next frame. Assert res while frame_valid high → frame_valid and outputs 0 before the next edge.
